// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined datapath: word-addressed RAM with a
// fixed access latency, stalling the pipeline until each load or store commits.
module dmem_responder #(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 3,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

  stateE          state;
  logic [CW-1:0]  count;
  logic           latStore;
  logic [AW-1:0]  latIdx;
  logic [31:0]    latData;
  logic [1:0]     latOff;
  logic [31:0]    mem [DEPTH];

  logic           req;
  logic           commit;
  logic           cStore;
  logic [AW-1:0]  cIdx;
  logic [31:0]    cData;
  logic [1:0]     cOff;
  logic           cMis;
  logic           unusedAddr;

  assign req        = mem_read | mem_write;
  assign stall      = ((state == IDLE) && req) || (state == WAIT);
  assign cMis       = (cOff != 2'b00);
  assign unusedAddr = ^addr[31:AW+2];

  // With a single-cycle latency the commit edge is the accept edge, so the
  // commit has to be taken straight from the live inputs rather than the latch.
  always_comb begin
    cStore = latStore;
    cIdx   = latIdx;
    cData  = latData;
    cOff   = latOff;
    commit = 1'b0;
    if (state == IDLE) begin
      cStore = mem_write;
      cIdx   = addr[AW+1:2];
      cData  = write_data;
      cOff   = addr[1:0];
      commit = req && (LATENCY == 1);
    end else if (state == WAIT) begin
      commit = (count == CW'(1));
    end
  end

  // RAM is deliberately not reset; a reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && cStore && !cMis)
      mem[cIdx] <= cData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      readdata   <= '0;
      misaligned <= 1'b0;
      latStore   <= 1'b0;
      latIdx     <= '0;
      latData    <= '0;
      latOff     <= 2'b00;
    end else begin
      misaligned <= 1'b0;
      if (commit) begin
        misaligned <= cMis;
        if (!cStore)
          readdata <= cMis ? 32'h0 : mem[cIdx];
      end
      case (state)
        IDLE: begin
          if (req) begin
            latStore <= mem_write;
            latIdx   <= addr[AW+1:2];
            latData  <= write_data;
            latOff   <= addr[1:0];
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          count <= count - 1'b1;
          if (count == CW'(1))
            state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 3 and latency 1) driven by
// an access task; expected responses flow through a scoreboard queue.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        rdReq  [2];
  logic        wrReq  [2];
  logic [31:0] addrIn [2];
  logic [31:0] dataIn [2];
  logic [31:0] rdata  [2];
  logic        stl    [2];
  logic        mis    [2];

  dmem_responder #(.DEPTH(64), .LATENCY(3)) dut3 (
    .clk(clk), .reset(rst[0]), .mem_read(rdReq[0]), .mem_write(wrReq[0]),
    .addr(addrIn[0]), .write_data(dataIn[0]), .readdata(rdata[0]),
    .stall(stl[0]), .misaligned(mis[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst[1]), .mem_read(rdReq[1]), .mem_write(wrReq[1]),
    .addr(addrIn[1]), .write_data(dataIn[1]), .readdata(rdata[1]),
    .stall(stl[1]), .misaligned(mis[1])
  );

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } expT;

  int          lat [2] = '{3, 1};
  expT         sbQ [$];
  logic [31:0] model [2][64];
  logic [31:0] lastRd [2];
  int          nChecks = 0;
  int          nErrors = 0;
  int          cyc = 0;
  int          rA, rB, rC;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Called just after a rising edge; returns with the request dropped just
  // after the edge that leaves RESP.
  task automatic access(input int w, input logic r, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        output int respCyc);
    expT        e;
    int         n;
    bit         done;
    logic [5:0] idx;
    logic       m;
    idx = a[7:2];
    m   = (a[1:0] != 2'b00);
    if (s) begin
      if (!m) model[w][idx] = d;
    end else begin
      lastRd[w] = m ? 32'h0 : model[w][idx];
    end
    e.rd  = lastRd[w];
    e.mis = m;
    sbQ.push_back(e);
    rdReq[w]  = r;
    wrReq[w]  = s;
    addrIn[w] = a;
    dataIn[w] = d;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (stl[w]) n++;
      else done = 1'b1;
    end
    respCyc = cyc;
    checkVal("respReached", {31'b0, done}, 32'd1);
    checkVal("stallCycles", 32'(n), 32'(lat[w]));
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal("readdata", rdata[w], e.rd);
      checkVal("misaligned", {31'b0, mis[w]}, {31'b0, e.mis});
    end
    @(posedge clk);
    #1;
    rdReq[w] = 1'b0;
    wrReq[w] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]    = 1'b1;
      rdReq[i]  = 1'b0;
      wrReq[i]  = 1'b0;
      addrIn[i] = 32'h0;
      dataIn[i] = 32'h0;
      lastRd[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkVal("rstReaddata", rdata[i], 32'h0);
      checkVal("rstStall", {31'b0, stl[i]}, 32'd0);
      checkVal("rstMisaligned", {31'b0, mis[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    // Latency 3: store then load, back to back
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rA);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, rB);
    checkVal("respSpacing3", 32'(rB - rA), 32'd4);

    // Read and write together behave as a store
    access(0, 1'b1, 1'b1, 32'h8, 32'h1234, rA);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, rA);

    // Misaligned store is dropped, misaligned load returns zero
    access(0, 1'b0, 1'b1, 32'h4, 32'h77, rA);
    access(0, 1'b0, 1'b1, 32'h6, 32'h55, rA);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, rA);
    access(0, 1'b1, 1'b0, 32'h6, 32'h0, rA);
    @(negedge clk);
    checkVal("misOneCycle", {31'b0, mis[0]}, 32'd0);
    checkVal("stallIdle", {31'b0, stl[0]}, 32'd0);
    checkVal("misLoadHold", rdata[0], 32'h0);
    @(posedge clk);
    #1;

    // Latency 1: alternating accesses, response every second cycle
    access(1, 1'b0, 1'b1, 32'h0, 32'hCAFE0001, rA);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, rB);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, rC);
    checkVal("respSpacing1a", 32'(rB - rA), 32'd2);
    checkVal("respSpacing1b", 32'(rC - rB), 32'd2);
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, rA);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, rA);

    // Reset in the second WAIT cycle aborts the store
    access(0, 1'b0, 1'b1, 32'h20, 32'h1111, rA);
    rdReq[0]  = 1'b0;
    wrReq[0]  = 1'b1;
    addrIn[0] = 32'h20;
    dataIn[0] = 32'hAAAA;
    @(negedge clk);
    checkVal("abortStallReq", {31'b0, stl[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkVal("abortStallWait", {31'b0, stl[0]}, 32'd1);
    @(posedge clk);
    #1;
    rst[0]   = 1'b1;
    wrReq[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0]    = 1'b0;
    lastRd[0] = 32'h0;
    @(negedge clk);
    checkVal("abortStall", {31'b0, stl[0]}, 32'd0);
    checkVal("abortReaddata", rdata[0], 32'h0);
    checkVal("abortMis", {31'b0, mis[0]}, 32'd0);
    @(posedge clk);
    #1;
    access(0, 1'b1, 1'b0, 32'h120, 32'h0, rA);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, rA);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
